timer_bank_arbiter: RTL
=======================

Name: timer_bank_arbiter

Overview:
- Shares the single register port of the general-purpose timer bank between the MCU's cores.
- Each core issues read/write requests. A round-robin FSM serialises them onto reg_en/reg_we/reg_addr/reg_wdata.
- Captures the bank's registered read data and returns a one-cycle acknowledge to the winning core.
- Sits between the per-core peripheral decoders and the timer bank.

Parameters:
- NUM_REQ, 2, number of requesting cores (2..4).
- ADDR_W, 4, timer-bank register address width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-core request; held until that core's req_ack
- req_we  in  NUM_REQ  per-core write enable (1 = write, 0 = read)
- req_addr  in  NUM_REQ*ADDR_W  per-core address, core k at [k*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  per-core write data, core k at [k*DATA_W +: DATA_W]
- req_ack  out  NUM_REQ  one-cycle completion pulse, one-hot or zero
- req_rdata  out  DATA_W  read data; valid only while req_ack is high
- req_err  out  1  access rejected; valid with req_ack
- own_map  in  2  timer-ownership map (bit t = owning core of timer t); used only with the optional feature
- reg_en  out  1  timer-bank access strobe
- reg_we  out  1  timer-bank write enable
- reg_addr  out  ADDR_W  timer-bank address
- reg_wdata  out  DATA_W  timer-bank write data
- reg_rdata  in  DATA_W  timer-bank read data; registered in the bank, valid one cycle after a read strobe
- busy  out  1  FSM not in IDLE
- grant_id  out  2  index of the core currently being served

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; round-robin pointer = 0, so core 0 has highest priority.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_valid is high, pick a winner round-robin, starting from the index after the last winner.
  - Latch the winner's we/addr/wdata into internal registers and set grant_id.
  - Go to ISSUE.
- ISSUE (exactly 1 cycle):
  - reg_en=1; reg_we, reg_addr and reg_wdata driven from the latched values.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - req_ack[grant_id]=1.
  - For a read, req_rdata = reg_rdata sampled this cycle. For a write, req_rdata = 0.
  - Update the pointer to grant_id; go to IDLE.
- Latency: req_valid first sampled at edge N -> reg_en high in cycle N+1 -> req_ack in cycle N+2.
  - Minimum 3 cycles per transaction; back-to-back service leaves one IDLE cycle between transactions.
- Outside ISSUE, reg_en=0 and reg_we=0; reg_addr and reg_wdata hold their last values.
- Request/ack ordering:
  - Requests are latched in IDLE, so changes to req_* after the grant do not affect the transaction in flight.
  - If req_valid drops after the grant, the transaction still completes and ack still pulses.
- Fairness:
  - A core that keeps req_valid high after its ack loses to any other requesting core.
  - With a single requester, that core is served every 3 cycles.
- Simultaneous requests: all cores requesting in the same IDLE cycle are served in rotation; no core waits more than NUM_REQ transactions.
- Reset mid-operation: return to IDLE; no ack is produced; reg_en drops in the same cycle as reset. The transaction in flight is lost, and requesters must re-issue it.
- grant_id width fixed at 2 bits; any unused upper bit reads 0.

Optional Feature:
- Macro TIMER_ARB_OWNERSHIP_EN (defined):
  - In IDLE, check the winner against own_map[addr[2]].
  - If the winner is not the owner, suppress the ISSUE strobe (reg_en stays 0) but keep ISSUE and RESP timing.
  - In RESP, assert req_err=1 and force req_rdata=0.
  - Owned accesses behave normally with req_err=0.
  - Supported only for NUM_REQ=2.
- Macro undefined: own_map is ignored, req_err is tied to 0, and every access passes through.

Decomposition:
- Package timer_arb_pkg holds:
  - arb_state_t enum (IDLE, ISSUE, RESP);
  - DEF_ADDR_W=4 and DEF_DATA_W=32;
  - timer register offsets: CTRL=0, COUNT=1, MATCH=2, PRESCALE=3;
  - TIMER_SEL_BIT=2.
- Sub-module rr_arbiter: combinational round-robin pick from a request vector and a last-grant pointer. Outputs a one-hot grant and its encoded index. Instantiated once.

Test Plan:
- Core0 writes addr 0x2, data 0x000000FF -> reg_en=1, reg_we=1, reg_addr=0x2 in cycle N+1; req_ack=01 in cycle N+2; bank MATCH0 reads back 0xFF.
- Core1 reads addr 0x6 with bank returning 0x12345678 -> req_ack=10 in cycle N+2; req_rdata=0x12345678; req_err=0.
- Both cores hold req_valid continuously for 6 transactions -> grant order 0,1,0,1,0,1; each ack spaced 3 cycles apart.
- Core0 requests, then rst pulses in its ISSUE cycle -> no req_ack; busy=0 the next cycle; reg_en=0; core0 is re-served after re-request with 3-cycle latency.
- With TIMER_ARB_OWNERSHIP_EN and own_map=2'b10, core0 writes addr 0x4 -> reg_en stays 0; req_ack=01 with req_err=1; req_rdata=0. Core1 writes addr 0x4 -> passes with req_err=0.

Source files
------------

// File: rtl/timer_arb_pkg.sv
// timer_arb_pkg: shared types and constants for the timer-bank register arbiter.
//   arb_state_t    - arbiter FSM state encoding
//   DEF_ADDR_W/DW  - default register address / data widths
//   REG_*          - per-timer register offsets inside the bank
//   TIMER_SEL_BIT  - address bit selecting which timer a register belongs to
package timer_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_COUNT    = 2'd1;
    localparam logic [1:0] REG_MATCH    = 2'd2;
    localparam logic [1:0] REG_PRESCALE = 2'd3;

    localparam int TIMER_SEL_BIT = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Ports:
//   req        in   NUM_REQ  request vector
//   last       in   2        index of the previous winner
//   last_valid in   1        0 until a first winner exists; search then starts at 0
//   grant      out  NUM_REQ  one-hot winner (zero when nothing requests)
//   grant_idx  out  2        encoded winner index
//   any        out  1        at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    input  logic               last_valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         grant_idx,
    output logic               any
);

    always_comb begin
        int start;
        int j;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        start     = last_valid ? (int'(last) + 1) : 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = start + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = 2'(j);
            end
        end
    end

endmodule

// File: rtl/timer_bank_arbiter.sv
// timer_bank_arbiter: serialises per-core register requests onto the single
// register port of the timer bank and returns a one-cycle ack to the winner.
//
// State | meaning
// IDLE  | waiting; picks a round-robin winner and latches its request
// ISSUE | one-cycle strobe to the bank from the latched request
// RESP  | one-cycle ack to the winner, read data passed from the bank
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/we/addr/wdata        per-core request (core k at slice k)
//   req_ack/rdata/err              one-hot completion pulse, read data, reject flag
//   own_map                        bit t = owning core of timer t
//   reg_en/we/addr/wdata, reg_rdata timer-bank register port
//   busy, grant_id                 FSM not idle, core being served
//
// Build option: TIMER_ARB_OWNERSHIP_EN rejects accesses by a core that does
// not own the addressed timer (NUM_REQ = 2 only). Without it own_map is
// ignored and req_err is 0.
module timer_bank_arbiter
    import timer_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      req_err,
    input  logic [1:0]                own_map,
    output logic                      reg_en,
    output logic                      reg_we,
    output logic [ADDR_W-1:0]         reg_addr,
    output logic [DATA_W-1:0]         reg_wdata,
    input  logic [DATA_W-1:0]         reg_rdata,
    output logic                      busy,
    output logic [1:0]                grant_id
);

    arb_state_t          state;
    logic [1:0]          ptr;
    logic                ptr_valid;
    logic [NUM_REQ-1:0]  win;
    logic [1:0]          win_idx;
    logic                win_any;
    logic [NUM_REQ-1:0]  lat_grant;
    logic                lat_we;
    logic                lat_deny;
    logic                en_q;
    logic                we_q;
    logic                sel_we;
    logic                sel_deny;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req_valid),
        .last       (ptr),
        .last_valid (ptr_valid),
        .grant      (win),
        .grant_idx  (win_idx),
        .any        (win_any)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win[k]) begin
                sel_we    = req_we[k];
                sel_addr  = req_addr[k*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef TIMER_ARB_OWNERSHIP_EN
    logic err_q;
    assign sel_deny = (own_map[sel_addr[TIMER_SEL_BIT]] != win_idx[0]);
    assign req_err  = err_q;

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= (state == ISSUE) && lat_deny;
    end
`else
    logic [1:0] unused_own_map;
    assign unused_own_map = own_map;
    assign sel_deny       = 1'b0;
    assign req_err        = 1'b0;
`endif

    // Strobes are gated by rst so the bank sees them drop in the reset cycle.
    assign reg_en    = en_q & ~rst;
    assign reg_we    = we_q & ~rst;
    assign req_rdata = (|req_ack && !lat_we && !lat_deny) ? reg_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            ptr_valid <= 1'b0;
            lat_grant <= '0;
            lat_we    <= 1'b0;
            lat_deny  <= 1'b0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            req_ack   <= '0;
            busy      <= 1'b0;
            grant_id  <= '0;
        end else begin
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            req_ack <= '0;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        grant_id  <= win_idx;
                        lat_grant <= win;
                        lat_we    <= sel_we;
                        lat_deny  <= sel_deny;
                        en_q      <= !sel_deny;
                        we_q      <= sel_we && !sel_deny;
                        reg_addr  <= sel_addr;
                        reg_wdata <= sel_wdata;
                    end
                end
                ISSUE: begin
                    state   <= RESP;
                    req_ack <= lat_grant;
                end
                RESP: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    ptr       <= grant_id;
                    ptr_valid <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
